// File: rtl/ifetch_seq.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_seq
// Description : Instruction-fetch stage. Holds the PC, fetches from a
//               wait-stated instruction ROM over a req/ready handshake,
//               presents each instruction for one execute cycle, then
//               computes the next PC from jump/branch controls. Misaligned
//               jump-register targets raise a sticky fault and halt.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 14
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       Instruction,
    output logic [31:0]       opcplus4,
    output logic              instr_valid,
    input  logic [31:0]       Add_result,
    input  logic [31:0]       Read_data_1,
    input  logic              Zero,
    input  logic              Branch,
    input  logic              nBranch,
    input  logic              Jmp,
    input  logic              Jal,
    input  logic              Jr,
    output logic              fetch_fault,
    output logic [31:0]       retired_count
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] w_next_pc;
    logic        w_jr_fault;

    // Handshake/valid are gated by reset so nothing is issued while held.
    assign imem_req    = (r_state == ST_FETCH) & ~reset;
    assign instr_valid = (r_state == ST_EXEC)  & ~reset;
    assign imem_addr   = r_pc[ADDR_W+1:2];
    assign opcplus4    = r_pc + 32'd4;

    // A JR to a non-word-aligned target is fatal; the PC is never loaded with it.
    assign w_jr_fault  = Jr & (Read_data_1[1:0] != 2'b00);

    // Next-PC selection: JR over J/JAL over taken branch over sequential.
    always_comb begin
        w_next_pc = opcplus4;
        if (Jr) begin
            w_next_pc = Read_data_1;
        end else if (Jmp | Jal) begin
            w_next_pc = {opcplus4[31:28], Instruction[25:0], 2'b00};
        end else if ((Branch & Zero) | (nBranch & ~Zero)) begin
            w_next_pc = Add_result;
        end
    end

    // Fetch/execute sequencer with PC, instruction latch, fault and retire count.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_state       <= ST_FETCH;
            Instruction   <= 32'h0;
            fetch_fault   <= 1'b0;
            retired_count <= 32'h0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        Instruction <= imem_rdata;
                        r_state     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (w_jr_fault) begin
                        fetch_fault <= 1'b1;
                        r_state     <= ST_FAULT;
                    end else begin
                        r_pc          <= w_next_pc;
                        retired_count <= retired_count + 32'd1;
                        r_state       <= ST_FETCH;
                    end
                end
                default: begin
                    // Halted until reset; everything holds.
                    r_state <= ST_FAULT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_seq
// Description : Self-checking bench for ifetch_seq. Expected execute-cycle
//               outputs are queued when the ROM answers and compared when
//               instr_valid is seen; PC, retire count and fault are modelled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_seq;

    localparam int ADDR_W = 14;

    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_JR   = 5'b10000;
    localparam logic [4:0] C_JMP  = 5'b01000;
    localparam logic [4:0] C_JAL  = 5'b00100;
    localparam logic [4:0] C_BR   = 5'b00010;
    localparam logic [4:0] C_NBR  = 5'b00001;

    logic              clock = 1'b0;
    logic              reset;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [31:0]       imem_rdata;
    logic [31:0]       Instruction;
    logic [31:0]       opcplus4;
    logic              instr_valid;
    logic [31:0]       Add_result;
    logic [31:0]       Read_data_1;
    logic              Zero, Branch, nBranch, Jmp, Jal, Jr;
    logic              fetch_fault;
    logic [31:0]       retired_count;

    ifetch_seq #(.RESET_PC(32'h0000_0000), .ADDR_W(ADDR_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .Instruction  (Instruction),
        .opcplus4     (opcplus4),
        .instr_valid  (instr_valid),
        .Add_result   (Add_result),
        .Read_data_1  (Read_data_1),
        .Zero         (Zero),
        .Branch       (Branch),
        .nBranch      (nBranch),
        .Jmp          (Jmp),
        .Jal          (Jal),
        .Jr           (Jr),
        .fetch_fault  (fetch_fault),
        .retired_count(retired_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] ret;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_pc, exp_ret, last_instr;
    logic        exp_fault;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_ctl();
        Jr = 0; Jmp = 0; Jal = 0; Branch = 0; nBranch = 0; Zero = 0;
        Add_result = 32'hDEAD_BEE0; Read_data_1 = 32'h0;
    endtask

    task automatic model_reset();
        exp_pc = 32'h0; exp_ret = 32'h0; exp_fault = 1'b0; last_instr = 32'h0;
        sb.delete();
    endtask

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        return 32'hA5C0_0000 ^ pc;
    endfunction

    // FETCH with 'waits' not-ready cycles, then ROM answers; ends at EXEC negedge.
    task automatic fetch_phase(input int waits, input logic [31:0] data);
        exp_t e;
        check("fetch_req", imem_req, 1);
        check("fetch_addr", imem_addr, exp_pc[ADDR_W+1:2]);
        // Control inputs outside EXEC must be ignored.
        Jr = 1; Jmp = 1; Read_data_1 = 32'h3; Add_result = 32'h4444;
        for (int w = 0; w < waits; w++) begin
            imem_ready = 0; imem_rdata = $urandom;
            @(negedge clock);
            check("wait_addr", imem_addr, exp_pc[ADDR_W+1:2]);
            check("wait_instr", Instruction, last_instr);
            check("wait_valid", instr_valid, 0);
            check("wait_req", imem_req, 1);
        end
        imem_ready = 1; imem_rdata = data;
        e.instr = data; e.pc4 = exp_pc + 32'd4; e.ret = exp_ret;
        sb.push_back(e);
        @(negedge clock);
        imem_ready = 1; imem_rdata = $urandom;  // ignored during EXEC
        clear_ctl();
    endtask

    task automatic exec_check();
        exp_t e;
        check("exec_valid", instr_valid, 1);
        check("exec_req", imem_req, 0);
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("exec_instr", Instruction, e.instr);
            check("exec_pc4", opcplus4, e.pc4);
            check("exec_ret", retired_count, e.ret);
        end
    endtask

    task automatic do_instr(input int waits, input logic [31:0] data, input logic [4:0] ctl,
                            input logic z, input logic [31:0] add, input logic [31:0] rd1);
        logic [31:0] pc4, nxt;
        fetch_phase(waits, data);
        exec_check();
        {Jr, Jmp, Jal, Branch, nBranch} = ctl;
        Zero = z; Add_result = add; Read_data_1 = rd1;
        pc4 = exp_pc + 32'd4;
        if (ctl[4])                              nxt = rd1;
        else if (ctl[3] | ctl[2])                nxt = {pc4[31:28], data[25:0], 2'b00};
        else if ((ctl[1] & z) | (ctl[0] & ~z))   nxt = add;
        else                                     nxt = pc4;
        if (ctl[4] && rd1[1:0] != 2'b00) exp_fault = 1'b1;
        else begin exp_pc = nxt; exp_ret = exp_ret + 32'd1; end
        last_instr = data;
        @(negedge clock);
        check("post_valid", instr_valid, 0);
        check("post_fault", fetch_fault, exp_fault);
        check("post_ret", retired_count, exp_ret);
        if (!exp_fault) begin
            check("post_req", imem_req, 1);
            check("post_addr", imem_addr, exp_pc[ADDR_W+1:2]);
            check("post_pc4", opcplus4, exp_pc + 32'd4);
        end
        imem_ready = 0;
        clear_ctl();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req"}, imem_req, 1);
        check({tag, "_addr"}, imem_addr, 0);
        check({tag, "_instr"}, Instruction, 0);
        check({tag, "_ret"}, retired_count, 0);
        check({tag, "_fault"}, fetch_fault, 0);
        check({tag, "_valid"}, instr_valid, 0);
        check({tag, "_pc4"}, opcplus4, 32'd4);
    endtask

    initial begin
        reset = 1; imem_ready = 0; imem_rdata = 32'h0;
        clear_ctl();
        model_reset();
        repeat (2) @(negedge clock);
        check("rst_req_held", imem_req, 0);
        check("rst_valid_held", instr_valid, 0);
        reset = 0; #1;
        check_reset_state("rst");

        // Sequential, zero-wait ROM.
        for (int i = 0; i < 3; i++) do_instr(0, rom_word(exp_pc), C_NONE, 0, 32'h0, 32'h0);
        check("seq_ret3", retired_count, 3);
        // Wait states.
        do_instr(3, rom_word(exp_pc), C_NONE, 0, 32'h0, 32'h0);
        // PC=0x10: BEQ taken -> 0x40.
        check("pc_is_10", {18'h0, imem_addr}, 32'h4);
        do_instr(0, rom_word(exp_pc), C_BR, 1, 32'h40, 32'h0);
        // BEQ not taken -> sequential.
        do_instr(1, rom_word(exp_pc), C_BR, 0, 32'h99, 32'h0);
        // BNE taken -> 0x80.
        do_instr(0, rom_word(exp_pc), C_NBR, 0, 32'h80, 32'h0);
        // Both branch kinds high, Zero=0 -> taken.
        do_instr(0, rom_word(exp_pc), C_BR | C_NBR, 0, 32'h120, 32'h0);
        // JR to 0x3000_0000, then JAL there.
        do_instr(0, rom_word(exp_pc), C_JR, 0, 32'h0, 32'h3000_0000);
        do_instr(2, 32'h0C00_0100, C_JAL, 0, 32'h0, 32'h0);
        check("jal_pc", exp_pc, 32'h3000_0400);
        // JR beats J.
        do_instr(0, 32'h0800_0FFF, C_JR | C_JMP, 1, 32'h500, 32'h200);
        // J at 0x200 -> 0x40.
        do_instr(0, 32'h0800_0010, C_JMP, 0, 32'h0, 32'h0);

        // Reset while a fetch is outstanding.
        imem_ready = 0;
        @(negedge clock);
        reset = 1; #1;
        check("rstf_req_low", imem_req, 0);
        @(negedge clock);
        reset = 0; model_reset(); #1;
        check_reset_state("rstf");
        // Response in the first cycle after release belongs to RESET_PC.
        do_instr(0, rom_word(exp_pc), C_NONE, 0, 32'h0, 32'h0);

        // Reset during EXEC: the jump must not land.
        fetch_phase(1, 32'h0800_0123);
        exec_check();
        Jmp = 1; reset = 1;
        @(negedge clock);
        reset = 0; clear_ctl(); model_reset(); imem_ready = 0; #1;
        check_reset_state("rste");

        // Fault on misaligned JR.
        do_instr(0, rom_word(exp_pc), C_NONE, 0, 32'h0, 32'h0);
        do_instr(0, rom_word(exp_pc), C_NONE, 0, 32'h0, 32'h0);
        do_instr(0, rom_word(exp_pc), C_JR, 0, 32'h0, 32'h202);
        for (int i = 0; i < 5; i++) begin
            imem_ready = 1; Jr = 1; Read_data_1 = 32'h400;
            check("flt_req", imem_req, 0);
            check("flt_valid", instr_valid, 0);
            check("flt_sticky", fetch_fault, 1);
            check("flt_ret", retired_count, exp_ret);
            check("flt_addr", imem_addr, exp_pc[ADDR_W+1:2]);
            check("flt_instr", Instruction, last_instr);
            @(negedge clock);
        end
        reset = 1; imem_ready = 0; clear_ctl();
        @(negedge clock);
        reset = 0; model_reset(); #1;
        check_reset_state("rstflt");
        do_instr(0, rom_word(exp_pc), C_NONE, 0, 32'h0, 32'h0);

        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
